// File: rtl/chroni_vga_pkg.sv
// Shared VGA timing types and standard mode constants for the chroni raster generator.
package chroni_vga_pkg;

  localparam int unsigned VGA_CNT_W = 12;

  typedef struct packed {
    logic [VGA_CNT_W-1:0] h_total;
    logic [VGA_CNT_W-1:0] h_sync_end;
    logic [VGA_CNT_W-1:0] h_de_start;
    logic [VGA_CNT_W-1:0] h_de_end;
    logic [VGA_CNT_W-1:0] h_pf_start;
    logic [VGA_CNT_W-1:0] h_pf_end;
    logic [VGA_CNT_W-1:0] v_total;
    logic [VGA_CNT_W-1:0] v_sync_end;
    logic [VGA_CNT_W-1:0] v_de_start;
    logic [VGA_CNT_W-1:0] v_de_end;
    logic [VGA_CNT_W-1:0] v_pf_start;
    logic [VGA_CNT_W-1:0] v_pf_end;
    logic                 h_sync_pol;
    logic                 v_sync_pol;
  } vga_timing_t;

  // Sync pulse starts at counter 0; display window follows the back porch.
  localparam vga_timing_t TIMING_640X480 = '{
    h_total: 12'd800,  h_sync_end: 12'd96,  h_de_start: 12'd144, h_de_end: 12'd784,
    h_pf_start: 12'd144, h_pf_end: 12'd784,
    v_total: 12'd525,  v_sync_end: 12'd2,   v_de_start: 12'd35,  v_de_end: 12'd515,
    v_pf_start: 12'd35, v_pf_end: 12'd515,
    h_sync_pol: 1'b0, v_sync_pol: 1'b0
  };

  localparam vga_timing_t TIMING_800X600 = '{
    h_total: 12'd1056, h_sync_end: 12'd128, h_de_start: 12'd216, h_de_end: 12'd1016,
    h_pf_start: 12'd216, h_pf_end: 12'd1016,
    v_total: 12'd628,  v_sync_end: 12'd4,   v_de_start: 12'd27,  v_de_end: 12'd627,
    v_pf_start: 12'd27, v_pf_end: 12'd627,
    h_sync_pol: 1'b1, v_sync_pol: 1'b1
  };

  localparam vga_timing_t TIMING_1920X1080 = '{
    h_total: 12'd2200, h_sync_end: 12'd44,  h_de_start: 12'd192, h_de_end: 12'd2112,
    h_pf_start: 12'd192, h_pf_end: 12'd2112,
    v_total: 12'd1125, v_sync_end: 12'd5,   v_de_start: 12'd41,  v_de_end: 12'd1121,
    v_pf_start: 12'd41, v_pf_end: 12'd1121,
    h_sync_pol: 1'b1, v_sync_pol: 1'b1
  };

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus sync / display / playfield window decode.
module vga_axis_counter
  import chroni_vga_pkg::*;
#(
  parameter int unsigned CNT_W = VGA_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             adv,
  input  logic [CNT_W-1:0] total,
  input  logic [CNT_W-1:0] sync_end,
  input  logic [CNT_W-1:0] de_start,
  input  logic [CNT_W-1:0] de_end,
  input  logic [CNT_W-1:0] pf_start,
  input  logic [CNT_W-1:0] pf_end,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             sync_act,
  output logic             de_win,
  output logic             pf_win
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wrap = adv && (cnt_q == total - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (adv) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign sync_act = cnt_q < sync_end;
  assign de_win   = (cnt_q >= de_start) && (cnt_q < de_end);
  assign pf_win   = (cnt_q >= pf_start) && (cnt_q < pf_end);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: shadowed runtime timing set applied at frame wrap, registered
// sync/enable/pulse outputs and a scaled line-buffer read index.
module vga_timing_gen
  import chroni_vga_pkg::*;
#(
  parameter int unsigned CNT_W        = VGA_CNT_W,
  parameter int unsigned IDX_W        = 11,
  parameter int unsigned LINE_LEN     = 640,
  parameter int unsigned MAX_SCALE    = 4,
  parameter int unsigned RENDER_LEAD  = 3,
  parameter vga_timing_t RESET_TIMING = TIMING_640X480,
  localparam int unsigned SCALE_W     = $clog2(MAX_SCALE + 1)
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [CNT_W-1:0]   cfg_h_total,
  input  logic [CNT_W-1:0]   cfg_h_sync_end,
  input  logic [CNT_W-1:0]   cfg_h_de_start,
  input  logic [CNT_W-1:0]   cfg_h_de_end,
  input  logic [CNT_W-1:0]   cfg_h_pf_start,
  input  logic [CNT_W-1:0]   cfg_h_pf_end,
  input  logic [CNT_W-1:0]   cfg_v_total,
  input  logic [CNT_W-1:0]   cfg_v_sync_end,
  input  logic [CNT_W-1:0]   cfg_v_de_start,
  input  logic [CNT_W-1:0]   cfg_v_de_end,
  input  logic [CNT_W-1:0]   cfg_v_pf_start,
  input  logic [CNT_W-1:0]   cfg_v_pf_end,
  input  logic               cfg_h_sync_pol,
  input  logic               cfg_v_sync_pol,
  input  logic [SCALE_W-1:0] cfg_scale_x,
  input  logic [SCALE_W-1:0] cfg_scale_y,
  output logic               cfg_pending,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               de,
  output logic               pf,
  output logic               frame_start,
  output logic               scanline_start,
  output logic               render_start,
  output logic               mode_changed,
  output logic               line_buf_sel,
  output logic [IDX_W-1:0]   pixel_buffer_index
);

  localparam logic [CNT_W-1:0] LEAD      = CNT_W'(RENDER_LEAD);
  localparam logic [IDX_W-1:0] HALF_BASE = IDX_W'(LINE_LEN);

  function automatic logic [SCALE_W-1:0] fix_scale(input logic [SCALE_W-1:0] s);
    return ((s == '0) || (s > SCALE_W'(MAX_SCALE))) ? SCALE_W'(1) : s;
  endfunction

  vga_timing_t        act_q, shd_q, cfg_set;
  logic [SCALE_W-1:0] sx_q, sy_q, shd_sx_q, shd_sy_q;
  logic               pending_q, applied_q, apply;

  logic [CNT_W-1:0]   x, y, y_next, render_line;
  logic               h_wrap, h_sync, h_de, h_pf;
  logic               v_wrap, v_sync, v_de, v_pf;
  logic               y_next_pf, idx_step;

  logic               sel_q, sel_d;
  logic [SCALE_W-1:0] lrep_q, lrep_d, rep_q, rep_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_base;

  logic hs_q, vs_q, de_q, pf_q, fs_q, ss_q, rs_q, mc_q;

  assign cfg_set = '{
    h_total: cfg_h_total, h_sync_end: cfg_h_sync_end, h_de_start: cfg_h_de_start,
    h_de_end: cfg_h_de_end, h_pf_start: cfg_h_pf_start, h_pf_end: cfg_h_pf_end,
    v_total: cfg_v_total, v_sync_end: cfg_v_sync_end, v_de_start: cfg_v_de_start,
    v_de_end: cfg_v_de_end, v_pf_start: cfg_v_pf_start, v_pf_end: cfg_v_pf_end,
    h_sync_pol: cfg_h_sync_pol, v_sync_pol: cfg_v_sync_pol
  };

  vga_axis_counter #(.CNT_W(CNT_W)) u_h_axis (
    .clk(vga_clk), .reset_n(reset_n), .adv(1'b1),
    .total(act_q.h_total), .sync_end(act_q.h_sync_end),
    .de_start(act_q.h_de_start), .de_end(act_q.h_de_end),
    .pf_start(act_q.h_pf_start), .pf_end(act_q.h_pf_end),
    .cnt(x), .wrap(h_wrap), .sync_act(h_sync), .de_win(h_de), .pf_win(h_pf)
  );

  vga_axis_counter #(.CNT_W(CNT_W)) u_v_axis (
    .clk(vga_clk), .reset_n(reset_n), .adv(h_wrap),
    .total(act_q.v_total), .sync_end(act_q.v_sync_end),
    .de_start(act_q.v_de_start), .de_end(act_q.v_de_end),
    .pf_start(act_q.v_pf_start), .pf_end(act_q.v_pf_end),
    .cnt(y), .wrap(v_wrap), .sync_act(v_sync), .de_win(v_de), .pf_win(v_pf)
  );

  // A write landing on the wrap cycle defers the switch by one frame.
  assign apply = v_wrap && pending_q && !cfg_we;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      act_q     <= RESET_TIMING;
      shd_q     <= RESET_TIMING;
      sx_q      <= SCALE_W'(1);
      sy_q      <= SCALE_W'(1);
      shd_sx_q  <= SCALE_W'(1);
      shd_sy_q  <= SCALE_W'(1);
      pending_q <= 1'b0;
      applied_q <= 1'b0;
    end else begin
      applied_q <= apply;
      if (cfg_we) begin
        shd_q     <= cfg_set;
        shd_sx_q  <= fix_scale(cfg_scale_x);
        shd_sy_q  <= fix_scale(cfg_scale_y);
        pending_q <= 1'b1;
      end else if (apply) begin
        pending_q <= 1'b0;
      end
      if (apply) begin
        act_q <= shd_q;
        sx_q  <= shd_sx_q;
        sy_q  <= shd_sy_q;
      end
    end
  end

  assign y_next      = v_wrap ? '0 : y + CNT_W'(1);
  assign y_next_pf   = (y_next >= act_q.v_pf_start) && (y_next < act_q.v_pf_end);
  assign render_line = (act_q.v_pf_start >= LEAD) ? act_q.v_pf_start - LEAD
                                                  : act_q.v_pf_start + act_q.v_total - LEAD;

  // Line-buffer half selection, updated at the line boundary so it is valid for the new line.
  always_comb begin
    sel_d  = sel_q;
    lrep_d = lrep_q;
    if (h_wrap && y_next_pf) begin
      if (y_next == act_q.v_pf_start) begin
        sel_d  = 1'b0;
        lrep_d = '0;
      end else if (lrep_q == sy_q - SCALE_W'(1)) begin
        sel_d  = ~sel_q;
        lrep_d = '0;
      end else begin
        lrep_d = lrep_q + SCALE_W'(1);
      end
    end
  end

  // Index leads pf by one cycle: base is loaded at h_pf_start-1, stepping inside the window.
  assign idx_base = sel_d ? HALF_BASE : '0;
  assign idx_step = h_pf && v_pf && (x != act_q.h_pf_end - CNT_W'(1));

  always_comb begin
    idx_d = idx_base;
    rep_d = '0;
    if (idx_step) begin
      if (rep_q == sx_q - SCALE_W'(1)) begin
        idx_d = idx_q + IDX_W'(1);
      end else begin
        idx_d = idx_q;
        rep_d = rep_q + SCALE_W'(1);
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      sel_q  <= 1'b0;
      lrep_q <= '0;
      rep_q  <= '0;
      idx_q  <= '0;
      hs_q   <= ~RESET_TIMING.h_sync_pol;
      vs_q   <= ~RESET_TIMING.v_sync_pol;
      de_q   <= 1'b0;
      pf_q   <= 1'b0;
      fs_q   <= 1'b0;
      ss_q   <= 1'b0;
      rs_q   <= 1'b0;
      mc_q   <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      lrep_q <= lrep_d;
      rep_q  <= rep_d;
      idx_q  <= idx_d;
      hs_q   <= (~h_sync) ^ act_q.h_sync_pol;
      vs_q   <= (~v_sync) ^ act_q.v_sync_pol;
      de_q   <= h_de && v_de;
      pf_q   <= h_pf && v_pf;
      fs_q   <= (x == '0) && (y == '0);
      ss_q   <= (x == '0);
      rs_q   <= (x == '0) && (y == render_line);
      mc_q   <= applied_q;
    end
  end

  assign cfg_pending        = pending_q;
  assign vga_hs             = hs_q;
  assign vga_vs             = vs_q;
  assign de                 = de_q;
  assign pf                 = pf_q;
  assign frame_start        = fs_q;
  assign scanline_start     = ss_q;
  assign render_start       = rs_q;
  assign mode_changed       = mc_q;
  assign line_buf_sel       = sel_q;
  assign pixel_buffer_index = idx_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 20x10 raster; a second instance covers a wrapping
// render lead.
module tb_vga_timing_gen;
  import chroni_vga_pkg::*;

  localparam vga_timing_t SIM_T = '{
    h_total: 12'd20, h_sync_end: 12'd2, h_de_start: 12'd4, h_de_end: 12'd18,
    h_pf_start: 12'd6, h_pf_end: 12'd16,
    v_total: 12'd10, v_sync_end: 12'd1, v_de_start: 12'd2, v_de_end: 12'd9,
    v_pf_start: 12'd3, v_pf_end: 12'd8,
    h_sync_pol: 1'b0, v_sync_pol: 1'b0
  };

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic        cfg_we;
  logic [11:0] cfg_h_total;
  logic [2:0]  cfg_scale_x, cfg_scale_y;

  logic        hs1, vs1, de1, pf1, fs1, ss1, rs1, mc1, sel1, pend1;
  logic        hs2, vs2, de2, pf2, fs2, ss2, rs2, mc2, sel2, pend2;
  logic [10:0] idx1, idx2;
  logic [20:0] o1, o2;

  assign o1 = {hs1, vs1, de1, pf1, fs1, ss1, rs1, mc1, sel1, pend1, idx1};
  assign o2 = {hs2, vs2, de2, pf2, fs2, ss2, rs2, mc2, sel2, pend2, idx2};

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(.RENDER_LEAD(3), .RESET_TIMING(SIM_T)) u_dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .cfg_we(cfg_we),
    .cfg_h_total(cfg_h_total), .cfg_h_sync_end(SIM_T.h_sync_end),
    .cfg_h_de_start(SIM_T.h_de_start), .cfg_h_de_end(SIM_T.h_de_end),
    .cfg_h_pf_start(SIM_T.h_pf_start), .cfg_h_pf_end(SIM_T.h_pf_end),
    .cfg_v_total(SIM_T.v_total), .cfg_v_sync_end(SIM_T.v_sync_end),
    .cfg_v_de_start(SIM_T.v_de_start), .cfg_v_de_end(SIM_T.v_de_end),
    .cfg_v_pf_start(SIM_T.v_pf_start), .cfg_v_pf_end(SIM_T.v_pf_end),
    .cfg_h_sync_pol(1'b0), .cfg_v_sync_pol(1'b0),
    .cfg_scale_x(cfg_scale_x), .cfg_scale_y(cfg_scale_y),
    .cfg_pending(pend1), .vga_hs(hs1), .vga_vs(vs1), .de(de1), .pf(pf1),
    .frame_start(fs1), .scanline_start(ss1), .render_start(rs1), .mode_changed(mc1),
    .line_buf_sel(sel1), .pixel_buffer_index(idx1)
  );

  vga_timing_gen #(.RENDER_LEAD(5), .RESET_TIMING(SIM_T)) u_dut_lead5 (
    .vga_clk(vga_clk), .reset_n(reset_n), .cfg_we(cfg_we),
    .cfg_h_total(cfg_h_total), .cfg_h_sync_end(SIM_T.h_sync_end),
    .cfg_h_de_start(SIM_T.h_de_start), .cfg_h_de_end(SIM_T.h_de_end),
    .cfg_h_pf_start(SIM_T.h_pf_start), .cfg_h_pf_end(SIM_T.h_pf_end),
    .cfg_v_total(SIM_T.v_total), .cfg_v_sync_end(SIM_T.v_sync_end),
    .cfg_v_de_start(SIM_T.v_de_start), .cfg_v_de_end(SIM_T.v_de_end),
    .cfg_v_pf_start(SIM_T.v_pf_start), .cfg_v_pf_end(SIM_T.v_pf_end),
    .cfg_h_sync_pol(1'b0), .cfg_v_sync_pol(1'b0),
    .cfg_scale_x(cfg_scale_x), .cfg_scale_y(cfg_scale_y),
    .cfg_pending(pend2), .vga_hs(hs2), .vga_vs(vs2), .de(de2), .pf(pf2),
    .frame_start(fs2), .scanline_start(ss2), .render_start(rs2), .mode_changed(mc2),
    .line_buf_sel(sel2), .pixel_buffer_index(idx2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Raster reference: counter position before the edge (cx,cy), decoded position (dx,dy).
  int cx, cy, dx, dy, ht, sx, sy, s_ht, s_sx, s_sy;
  bit m_pend, mc_arm, exp_mc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int fix_scale(input int s);
    return (s == 0 || s > 4) ? 1 : s;
  endfunction

  function automatic int exp_sel(input int line);
    return (line >= 3 && line < 8) ? ((line - 3) / sy) % 2 : 0;
  endfunction

  task automatic tick();
    bit fwrap;
    @(posedge vga_clk);
    dx     = cx;
    dy     = cy;
    exp_mc = mc_arm;
    mc_arm = 1'b0;
    if (!reset_n) begin
      cx = 0; cy = 0; ht = 20; sx = 1; sy = 1; m_pend = 1'b0; exp_mc = 1'b0;
    end else begin
      fwrap = (cx == ht - 1) && (cy == 9);
      if (cx == ht - 1) begin
        cx = 0;
        cy = (cy == 9) ? 0 : cy + 1;
      end else begin
        cx = cx + 1;
      end
      if (fwrap && m_pend && !cfg_we) begin
        ht = s_ht; sx = s_sx; sy = s_sy; m_pend = 1'b0; mc_arm = 1'b1;
      end
      if (cfg_we) begin
        s_ht   = int'(cfg_h_total);
        s_sx   = fix_scale(int'(cfg_scale_x));
        s_sy   = fix_scale(int'(cfg_scale_y));
        m_pend = 1'b1;
      end
    end
    #1;
  endtask

  task automatic check_unit(input string who, input logic [20:0] o, input int rs_line);
    int line, xp, ei;
    line = (dx == ht - 1) ? ((dy == 9) ? 0 : dy + 1) : dy;
    xp   = dx + 1;
    if (dy >= 3 && dy < 8 && xp >= 6 && xp < 16) ei = exp_sel(dy) * 640 + (xp - 6) / sx;
    else ei = exp_sel(line) * 640;
    check_eq({who, ".hs"},   32'(o[20]), 32'(dx >= 2));
    check_eq({who, ".vs"},   32'(o[19]), 32'(dy >= 1));
    check_eq({who, ".de"},   32'(o[18]), 32'(dx >= 4 && dx < 18 && dy >= 2 && dy < 9));
    check_eq({who, ".pf"},   32'(o[17]), 32'(dx >= 6 && dx < 16 && dy >= 3 && dy < 8));
    check_eq({who, ".fs"},   32'(o[16]), 32'(dx == 0 && dy == 0));
    check_eq({who, ".ss"},   32'(o[15]), 32'(dx == 0));
    check_eq({who, ".rs"},   32'(o[14]), 32'(dx == 0 && dy == rs_line));
    check_eq({who, ".mc"},   32'(o[13]), 32'(exp_mc));
    check_eq({who, ".sel"},  32'(o[12]), 32'(exp_sel(line)));
    check_eq({who, ".pend"}, 32'(o[11]), 32'(m_pend));
    check_eq({who, ".idx"},  32'(o[10:0]), 32'(ei));
  endtask

  task automatic check_reset(input string who, input logic [20:0] o);
    check_eq({who, ".rst_hs"},  32'(o[20]), 32'd1);
    check_eq({who, ".rst_vs"},  32'(o[19]), 32'd1);
    check_eq({who, ".rst_flags"}, 32'(o[18:11]), 32'd0);
    check_eq({who, ".rst_idx"}, 32'(o[10:0]), 32'd0);
  endtask

  task automatic step_check();
    tick();
    check_unit("u1", o1, 0);
    check_unit("u5", o2, 8);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_check();
  endtask

  task automatic program_cfg(input int h_total, input int scx, input int scy);
    cfg_h_total = 12'(h_total);
    cfg_scale_x = 3'(scx);
    cfg_scale_y = 3'(scy);
    cfg_we      = 1'b1;
    step_check();
    cfg_we      = 1'b0;
  endtask

  initial begin
    bit reached;
    reset_n = 1'b0; cfg_we = 1'b0; cfg_h_total = 12'd20; cfg_scale_x = 3'd1; cfg_scale_y = 3'd1;
    cx = 0; cy = 0; ht = 20; sx = 1; sy = 1; s_ht = 20; s_sx = 1; s_sy = 1;
    m_pend = 1'b0; mc_arm = 1'b0; exp_mc = 1'b0;

    repeat (3) tick();
    check_reset("u1", o1);
    check_reset("u5", o2);
    reset_n = 1'b1;

    // Default 1x scaling, one full frame plus part of the next.
    run(250);

    // 2x2 scaling requested mid-frame, applied at the next wrap.
    program_cfg(20, 2, 2);
    run(400);

    // Longer lines requested mid-frame; current frame finishes in 20-pixel timing.
    run(60);
    program_cfg(24, 1, 1);
    run(400);

    // Pending set, then a second write exactly on the wrap cycle defers the switch.
    program_cfg(20, 2, 2);
    reached = 1'b0;
    for (int i = 0; i < 400 && !reached; i++) begin
      if (cx == ht - 1 && cy == 9) reached = 1'b1;
      else step_check();
    end
    check_eq("wrap_reached", 32'(reached), 32'd1);
    program_cfg(20, 0, 1);
    run(460);

    // Reset mid-line discards a pending set.
    run(7);
    program_cfg(24, 2, 2);
    reset_n = 1'b0;
    tick();
    check_reset("u1_mid", o1);
    check_reset("u5_mid", o2);
    reset_n = 1'b1;
    run(230);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
